// File: rtl/lcd_frame_writer.sv
// Frame feeder for the SPI LCD transmitter FIFO: window/RAMWR preamble in byte mode, then pixels in word mode.
// Define LCD_TEST_PATTERN_EN to replace the pixel input with built-in vertical colour bars.
`timescale 1ns/1ps
module lcd_frame_writer #(
  parameter int X_START    = 0,
  parameter int Y_START    = 0,
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 160,
  parameter int GAP8       = 16,
  parameter int GAP16      = 32,
  parameter int FIFO_LIMIT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_pix_valid,
  input  logic [15:0] i_pix_data,
  output logic        o_pix_ready,
  input  logic        i_init_done,
  input  logic        i_running,
  output logic        o_en,
  output logic        o_we,
  output logic        o_mode,
  output logic [15:0] o_data,
  output logic        o_busy,
  output logic        o_frame_done
);

  typedef enum logic [2:0] {IDLE, WAIT_INIT, CMD, CMD_DRAIN, PIX, PIX_DRAIN} state_e;

  localparam logic [7:0]  X_FIRST    = 8'(X_START);
  localparam logic [7:0]  X_LAST     = 8'(X_START + WIDTH - 1);
  localparam logic [7:0]  Y_FIRST    = 8'(Y_START);
  localparam logic [7:0]  Y_LAST     = 8'(Y_START + HEIGHT - 1);
  localparam logic [14:0] PIX_LAST   = 15'(WIDTH * HEIGHT - 1);
  localparam logic [8:0]  LIMIT      = 9'(FIFO_LIMIT);
  localparam logic [15:0] GAP8_LAST  = 16'(GAP8 - 1);
  localparam logic [15:0] GAP16_LAST = 16'(GAP16 - 1);

  state_e      state_q, state_d;
  logic [3:0]  cmd_idx_q, cmd_idx_d;
  logic [14:0] pix_cnt_q, pix_cnt_d;
  logic [8:0]  occ_q, occ_d;
  logic [15:0] timer_q, timer_d;
  logic        en_q;
  logic        we_q, we_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [15:0] data_q, data_d;
  logic [15:0] cmd_word, pix_word;
  logic        has_credit, drained, drain, pix_take;

  assign has_credit = occ_q < LIMIT;
  assign drained    = (occ_q == 9'd0) && !i_running;

  // Byte-mode words carry the byte in [15:8] and D/C in bit 0.
  always_comb begin
    cmd_word = 16'h0000;
    case (cmd_idx_q)
      4'd0:                   cmd_word = 16'h2A00;
      4'd1, 4'd3, 4'd6, 4'd8: cmd_word = 16'h0001;
      4'd2:                   cmd_word = {X_FIRST, 8'h01};
      4'd4:                   cmd_word = {X_LAST, 8'h01};
      4'd5:                   cmd_word = 16'h2B00;
      4'd7:                   cmd_word = {Y_FIRST, 8'h01};
      4'd9:                   cmd_word = {Y_LAST, 8'h01};
      4'd10:                  cmd_word = 16'h2C00;
      default:                cmd_word = 16'h0000;
    endcase
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam int         BAR_W    = (WIDTH >= 8) ? WIDTH / 8 : 1;
  localparam logic [7:0] COL_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] BAR_LAST = 8'(BAR_W - 1);

  logic [7:0] col_q, col_d;
  logic [7:0] bar_cnt_q, bar_cnt_d;
  logic [2:0] bar_q, bar_d;

  assign o_pix_ready = 1'b0;
  assign pix_take    = (state_q == PIX) && has_credit;

  always_comb begin
    pix_word = 16'h0000;
    case (bar_q)
      3'd0: pix_word = 16'hF800;
      3'd1: pix_word = 16'h07E0;
      3'd2: pix_word = 16'h001F;
      3'd3: pix_word = 16'hFFE0;
      3'd4: pix_word = 16'hF81F;
      3'd5: pix_word = 16'h07FF;
      3'd6: pix_word = 16'hFFFF;
      default: pix_word = 16'h0000;
    endcase
  end

  // Bar index saturates at 7 so widths not divisible by 8 pad the last bar.
  always_comb begin
    col_d     = col_q;
    bar_cnt_d = bar_cnt_q;
    bar_d     = bar_q;
    if (state_q == IDLE || (pix_take && col_q == COL_LAST)) begin
      col_d     = 8'd0;
      bar_cnt_d = 8'd0;
      bar_d     = 3'd0;
    end else if (pix_take) begin
      col_d = col_q + 8'd1;
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = 8'd0;
        bar_d     = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= 8'd0;
      bar_cnt_q <= 8'd0;
      bar_q     <= 3'd0;
    end else begin
      col_q     <= col_d;
      bar_cnt_q <= bar_cnt_d;
      bar_q     <= bar_d;
    end
  end
`else
  assign o_pix_ready = (state_q == PIX) && has_credit;
  assign pix_take    = o_pix_ready && i_pix_valid;
  assign pix_word    = i_pix_data;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    pix_cnt_d = pix_cnt_q;
    mode_d    = mode_q;
    data_d    = data_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          cmd_idx_d = 4'd0;
          pix_cnt_d = 15'd0;
          state_d   = i_init_done ? CMD : WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (i_init_done) state_d = CMD;
      end
      CMD: begin
        if (has_credit) begin
          we_d      = 1'b1;
          data_d    = cmd_word;
          cmd_idx_d = cmd_idx_q + 4'd1;
          if (cmd_idx_q == 4'd10) state_d = CMD_DRAIN;
        end
      end
      CMD_DRAIN: begin
        if (drained) begin
          mode_d  = 1'b1;
          state_d = PIX;
        end
      end
      PIX: begin
        if (pix_take) begin
          we_d      = 1'b1;
          data_d    = pix_word;
          pix_cnt_d = pix_cnt_q + 15'd1;
          if (pix_cnt_q == PIX_LAST) state_d = PIX_DRAIN;
        end
      end
      PIX_DRAIN: begin
        if (drained) begin
          mode_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy counts a word from the edge its write pulse becomes visible, so credit never overshoots.
  always_comb begin
    drain   = (occ_q != 9'd0) && (timer_q == (mode_q ? GAP16_LAST : GAP8_LAST));
    timer_d = timer_q;
    if (occ_q == 9'd0 || drain) timer_d = 16'd0;
    else                        timer_d = timer_q + 16'd1;
    occ_d = occ_q + {8'd0, we_d} - {8'd0, drain};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_idx_q <= 4'd0;
      pix_cnt_q <= 15'd0;
      occ_q     <= 9'd0;
      timer_q   <= 16'd0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      pix_cnt_q <= pix_cnt_d;
      occ_q     <= occ_d;
      timer_q   <= timer_d;
      en_q      <= 1'b1;
      we_q      <= we_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      data_q    <= data_d;
    end
  end

  assign o_en         = en_q;
  assign o_we         = we_q;
  assign o_mode       = mode_q;
  assign o_data       = data_q;
  assign o_frame_done = done_q;
  assign o_busy       = state_q != IDLE;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomized self-checking bench for lcd_frame_writer using a small window and short drain gaps.
`timescale 1ns/1ps
module tb_lcd_frame_writer;

  localparam int XS    = 3;
  localparam int YS    = 250;
  localparam int W     = 16;
  localparam int H     = 8;
  localparam int G8    = 4;
  localparam int G16   = 8;
  localparam int LIM   = 12;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_pix_valid = 1'b0;
  logic [15:0] i_pix_data = 16'h0000;
  logic        i_init_done = 1'b0;
  logic        i_running = 1'b0;
  logic        o_pix_ready, o_en, o_we, o_mode, o_busy, o_frame_done;
  logic [15:0] o_data;

  always #5 clk = ~clk;

  lcd_frame_writer #(
    .X_START(XS), .Y_START(YS), .WIDTH(W), .HEIGHT(H),
    .GAP8(G8), .GAP16(G16), .FIFO_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .i_init_done(i_init_done), .i_running(i_running),
    .o_en(o_en), .o_we(o_we), .o_mode(o_mode), .o_data(o_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [16:0] wrQ[$];
  int          wrT[$];
  logic [15:0] pixExp[$];
  int          doneT[$];
  logic [15:0] expPre[11];

  function automatic logic [15:0] byteWord(input logic [7:0] b, input logic dc);
    return {b, 7'b0, dc};
  endfunction

  function automatic void buildPreamble();
    expPre[0]  = byteWord(8'h2A, 1'b0);
    expPre[1]  = byteWord(8'h00, 1'b1);
    expPre[2]  = byteWord(8'(XS), 1'b1);
    expPre[3]  = byteWord(8'h00, 1'b1);
    expPre[4]  = byteWord(8'((XS + W - 1) % 256), 1'b1);
    expPre[5]  = byteWord(8'h2B, 1'b0);
    expPre[6]  = byteWord(8'h00, 1'b1);
    expPre[7]  = byteWord(8'(YS), 1'b1);
    expPre[8]  = byteWord(8'h00, 1'b1);
    expPre[9]  = byteWord(8'((YS + H - 1) % 256), 1'b1);
    expPre[10] = byteWord(8'h2C, 1'b0);
  endfunction

  function automatic logic [16:0] wrAt(input int i);
    return (i < wrQ.size()) ? wrQ[i] : 17'h1FFFF;
  endfunction

  function automatic int pixWrites();
    int n = 0;
    foreach (wrQ[i]) if (wrQ[i][16]) n++;
    return n;
  endfunction

  function automatic int streamErrors();
    int k = 0;
    int e = 0;
    foreach (wrQ[i]) begin
      if (wrQ[i][16]) begin
        if (k >= pixExp.size() || wrQ[i][15:0] !== pixExp[k]) e++;
        k++;
      end
    end
    if (k != pixExp.size()) e++;
    return e;
  endfunction

  function automatic int preambleErrors();
    int e = 0;
    for (int i = 0; i < 11; i++) if (wrAt(i) !== {1'b0, expPre[i]}) e++;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_we) begin
      wrQ.push_back({o_mode, o_data});
      wrT.push_back(cyc);
    end
    if (o_frame_done) doneT.push_back(cyc);
  endtask

  task automatic drivePix(input bit rnd);
    i_pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    i_pix_data  = 16'($urandom);
    if (i_pix_valid && o_pix_ready) pixExp.push_back(i_pix_data);
  endtask

  task automatic clearLog();
    wrQ.delete();
    wrT.delete();
    pixExp.delete();
    doneT.delete();
  endtask

  task automatic pulseStart();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic waitMode(output int rise);
    rise = -1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (o_mode) begin
        rise = (wrT.size() > 0) ? cyc - wrT[0] : -1;
        break;
      end
    end
  endtask

  task automatic runPixels(input bit rnd, input int startAt);
    for (int n = 0; n < 8000 && doneT.size() == 0; n++) begin
      drivePix(rnd);
      i_start = (n == startAt);
      tick();
    end
    i_start     = 1'b0;
    i_pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++; if (o_en !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_en: got %b want 0", o_en); end
    vectors++; if (o_we !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_we: got %b want 0", o_we); end
    vectors++; if (o_mode !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_mode: got %b want 0", o_mode); end
    vectors++; if (o_data !== 16'h0)    begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0000", o_data); end
    vectors++; if (o_pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", o_pix_ready); end
    vectors++; if (o_busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", o_busy); end
    vectors++; if (o_frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", o_frame_done); end
    reset = 1'b0;
    tick();
    vectors++; if (o_en !== 1'b1) begin miscompares++; $display("[TB] FAIL en_after_reset: got %b want 1", o_en); end
  endtask

  task automatic test_full_frame();
    int t0, lat, pFirst, r, rise, expRise, p0, dropIdx, occNow, occPrev, gap, k;
    bit dropSeen;
    clearLog();
    i_init_done = 1'b1;
    i_running   = 1'b1;
    i_pix_valid = 1'b0;
    t0 = cyc;
    pulseStart();
    for (int n = 0; n < 30 && wrQ.size() < 11; n++) tick();
    lat = (wrT.size() > 0) ? wrT[0] - t0 : -1;
    vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL start_latency: got %0d want 2", lat); end
    vectors++; if (wrQ.size() !== 11) begin miscompares++; $display("[TB] FAIL preamble_len: got %0d want 11", wrQ.size()); end
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (wrAt(i) !== {1'b0, expPre[i]}) begin
        miscompares++;
        $display("[TB] FAIL preamble[%0d]: got %h want %h", i, wrAt(i), {1'b0, expPre[i]});
      end
    end

    pFirst  = (wrT.size() > 0) ? wrT[0] : cyc;
    r       = $urandom_range(11, 80);
    expRise = ((11 * G8 > r) ? 11 * G8 : r) + 1;
    rise    = -1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (cyc - pFirst == r) begin
        vectors++;
        if (o_mode !== 1'b0 || o_pix_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL mode_early: got mode=%b ready=%b want 0/0", o_mode, o_pix_ready);
        end
        i_running = 1'b0;
      end
      if (o_mode) begin
        rise = cyc - pFirst;
        break;
      end
    end
    vectors++; if (rise !== expRise) begin miscompares++; $display("[TB] FAIL mode_rise: got %0d want %0d", rise, expRise); end
    vectors++; if (wrQ.size() !== 11) begin miscompares++; $display("[TB] FAIL word_before_mode: got %0d writes want 11", wrQ.size()); end

    dropSeen = 1'b0;
    dropIdx  = 0;
    p0       = -1;
    for (int n = 0; n < TOTAL * G16 + 300 && doneT.size() == 0; n++) begin
      drivePix(1'b0);
      tick();
      if (p0 < 0 && wrQ.size() > 11) p0 = wrT[11];
      if (!dropSeen && p0 >= 0 && o_busy && o_mode && !o_pix_ready) begin
        occNow  = (wrQ.size() - 11) - (cyc - p0) / G16;
        occPrev = (wrQ.size() - 11 - (o_we ? 1 : 0)) - (cyc - 1 - p0) / G16;
        vectors++; if (occNow !== LIM) begin miscompares++; $display("[TB] FAIL ready_drop_occ: got %0d want %0d", occNow, LIM); end
        vectors++; if (!(occPrev < LIM)) begin miscompares++; $display("[TB] FAIL ready_prev_occ: got %0d want <%0d", occPrev, LIM); end
        dropSeen = 1'b1;
        dropIdx  = wrQ.size();
      end
      if (o_frame_done) begin
        vectors++; if (o_mode !== 1'b0) begin miscompares++; $display("[TB] FAIL mode_at_done: got %b want 0", o_mode); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_at_done: got %b want 0", o_busy); end
      end
    end
    i_pix_valid = 1'b0;
    vectors++; if (dropSeen !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_drop_seen: got %b want 1", dropSeen); end
    for (int j = 0; j < 4; j++) begin
      k   = dropIdx + j;
      gap = (k + 1 < wrT.size()) ? wrT[k + 1] - wrT[k] : -1;
      vectors++; if (gap !== G16) begin miscompares++; $display("[TB] FAIL steady_gap[%0d]: got %0d want %0d", j, gap, G16); end
    end
    vectors++; if (pixWrites() !== TOTAL) begin miscompares++; $display("[TB] FAIL pix_count: got %0d want %0d", pixWrites(), TOTAL); end
    vectors++; if (pixExp.size() !== TOTAL) begin miscompares++; $display("[TB] FAIL accepted_count: got %0d want %0d", pixExp.size(), TOTAL); end
    vectors++; if (streamErrors() !== 0) begin miscompares++; $display("[TB] FAIL pix_stream: got %0d bad words want 0", streamErrors()); end
    vectors++;
    if (doneT.size() !== 1 || (doneT.size() > 0 && doneT[0] - p0 !== TOTAL * G16 + 1)) begin
      miscompares++;
      $display("[TB] FAIL done_time: got count %0d at %0d want 1 at %0d",
               doneT.size(), (doneT.size() > 0) ? doneT[0] - p0 : -1, TOTAL * G16 + 1);
    end
    tick();
    vectors++; if (o_frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_width: got %b want 0", o_frame_done); end
  endtask

  task automatic test_wait_init();
    int k, ki, lat, rise, nWr;
    clearLog();
    i_init_done = 1'b0;
    i_running   = 1'b0;
    pulseStart();
    k = $urandom_range(5, 30);
    repeat (k) tick();
    vectors++; if (wrQ.size() !== 0) begin miscompares++; $display("[TB] FAIL write_before_init: got %0d want 0", wrQ.size()); end
    vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_wait_init: got %b want 1", o_busy); end
    i_init_done = 1'b1;
    ki = cyc;
    for (int n = 0; n < 20 && wrQ.size() == 0; n++) tick();
    lat = (wrT.size() > 0) ? wrT[0] - ki : -1;
    vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL init_latency: got %0d want 2", lat); end
    waitMode(rise);
    vectors++; if (rise !== 11 * G8 + 1) begin miscompares++; $display("[TB] FAIL init_mode_rise: got %0d want %0d", rise, 11 * G8 + 1); end
    runPixels(1'b1, 20);
    vectors++; if (preambleErrors() !== 0) begin miscompares++; $display("[TB] FAIL init_preamble: got %0d bad words want 0", preambleErrors()); end
    vectors++; if (pixWrites() !== TOTAL) begin miscompares++; $display("[TB] FAIL start_in_pix_count: got %0d want %0d", pixWrites(), TOTAL); end
    vectors++; if (streamErrors() !== 0) begin miscompares++; $display("[TB] FAIL random_stream: got %0d bad words want 0", streamErrors()); end
    nWr = wrQ.size();
    repeat (20) tick();
    vectors++; if (wrQ.size() !== nWr) begin miscompares++; $display("[TB] FAIL writes_after_done: got %0d want %0d", wrQ.size(), nWr); end
    vectors++; if (doneT.size() !== 1) begin miscompares++; $display("[TB] FAIL done_count: got %0d want 1", doneT.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int rise;
    clearLog();
    i_init_done = 1'b1;
    i_running   = 1'b0;
    pulseStart();
    for (int n = 0; n < 600 && pixWrites() < 10; n++) begin
      drivePix(1'b0);
      tick();
    end
    reset       = 1'b1;
    i_init_done = 1'b0;
    i_pix_valid = 1'b0;
    tick();
    vectors++;
    if ({o_en, o_we, o_mode, o_data, o_pix_ready, o_busy, o_frame_done} !== 22'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got en=%b we=%b mode=%b data=%h rdy=%b busy=%b done=%b want all 0",
               o_en, o_we, o_mode, o_data, o_pix_ready, o_busy, o_frame_done);
    end
    reset = 1'b0;
    tick();
    vectors++; if (o_en !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset_en: got %b want 1", o_en); end
    repeat (5) tick();
    clearLog();
    i_init_done = 1'b1;
    pulseStart();
    for (int n = 0; n < 30 && wrQ.size() < 11; n++) tick();
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (wrAt(i) !== {1'b0, expPre[i]}) begin
        miscompares++;
        $display("[TB] FAIL replay_preamble[%0d]: got %h want %h", i, wrAt(i), {1'b0, expPre[i]});
      end
    end
    waitMode(rise);
    vectors++; if (rise !== 11 * G8 + 1) begin miscompares++; $display("[TB] FAIL replay_mode_rise: got %0d want %0d", rise, 11 * G8 + 1); end
    runPixels(1'b0, -1);
    vectors++; if (pixWrites() !== TOTAL) begin miscompares++; $display("[TB] FAIL replay_count: got %0d want %0d", pixWrites(), TOTAL); end
    vectors++; if (streamErrors() !== 0) begin miscompares++; $display("[TB] FAIL replay_stream: got %0d bad words want 0", streamErrors()); end
    vectors++; if (doneT.size() !== 1) begin miscompares++; $display("[TB] FAIL replay_done: got %0d want 1", doneT.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    buildPreamble();
    test_reset();
    test_full_frame();
    test_wait_init();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
